id_ex_stage: RTL and testbench

- ID/EX pipeline register plus execute-stage operand selection.
- Captures decoded controls and operands from decode and holds them for one stage.
- Applies forwarding from MEM and WB and produces the operand pair (SrcAE/SrcBE) and ALUControlE for the execute ALU.
- Also produces WriteDataE and WriteRegE for the downstream EX/MEM register.

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage forwarding and operand selection.
// Holds decoded controls/operands for one stage and builds SrcAE/SrcBE for the ALU.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallE,
  input  logic          FlushE,
  input  logic          ValidD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          MemWriteD,
  input  logic          ALUSrcD,
  input  logic          RegDstD,
  input  logic [2:0]    ALUControlD,
  input  logic [DW-1:0] RD1D,
  input  logic [DW-1:0] RD2D,
  input  logic [DW-1:0] SignImmD,
  input  logic [RW-1:0] RsD,
  input  logic [RW-1:0] RtD,
  input  logic [RW-1:0] RdD,
  input  logic [1:0]    ForwardAE,
  input  logic [1:0]    ForwardBE,
  input  logic [DW-1:0] ALUOutM,
  input  logic [DW-1:0] ResultW,
  output logic          ValidE,
  output logic          RegWriteE,
  output logic          MemtoRegE,
  output logic          MemWriteE,
  output logic [2:0]    ALUControlE,
  output logic [DW-1:0] SrcAE,
  output logic [DW-1:0] SrcBE,
  output logic [DW-1:0] WriteDataE,
  output logic [RW-1:0] WriteRegE,
  output logic [RW-1:0] RsE,
  output logic [RW-1:0] RtE
);

  logic          valid_q,    valid_d;
  logic          regwrite_q, regwrite_d;
  logic          memtoreg_q, memtoreg_d;
  logic          memwrite_q, memwrite_d;
  logic          alusrc_q,   alusrc_d;
  logic          regdst_q,   regdst_d;
  logic [2:0]    aluctrl_q,  aluctrl_d;
  logic [DW-1:0] rd1_q,      rd1_d;
  logic [DW-1:0] rd2_q,      rd2_d;
  logic [DW-1:0] signimm_q,  signimm_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [RW-1:0] rd_q,       rd_d;

  // Next-state priority: flush (full bubble) > stall (hold) > load.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    regdst_d   = regdst_q;
    aluctrl_d  = aluctrl_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    signimm_d  = signimm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    if (FlushE) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      regdst_d   = 1'b0;
      aluctrl_d  = 3'b000;
      rd1_d      = '0;
      rd2_d      = '0;
      signimm_d  = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
    end else if (!StallE) begin
      valid_d    = ValidD;
      // An invalid slot may carry stale controls but must never write.
      regwrite_d = RegWriteD & ValidD;
      memwrite_d = MemWriteD & ValidD;
      memtoreg_d = MemtoRegD;
      alusrc_d   = ALUSrcD;
      regdst_d   = RegDstD;
      aluctrl_d  = ALUControlD;
      rd1_d      = RD1D;
      rd2_d      = RD2D;
      signimm_d  = SignImmD;
      rs_d       = RsD;
      rt_d       = RtD;
      rd_d       = RdD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      aluctrl_q  <= 3'b000;
      rd1_q      <= '0;
      rd2_q      <= '0;
      signimm_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      aluctrl_q  <= aluctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      signimm_q  <= signimm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
    end
  end

  // Select 11 is reserved and falls back to the register-file value.
  function automatic logic [DW-1:0] fwd_sel(input logic [1:0]    sel,
                                            input logic [DW-1:0] reg_val,
                                            input logic [DW-1:0] mem_val,
                                            input logic [DW-1:0] wb_val);
    logic [DW-1:0] r;
    case (sel)
      2'b10:   r = mem_val;
      2'b01:   r = wb_val;
      default: r = reg_val;
    endcase
    return r;
  endfunction

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  always_comb begin
    fwd_a = fwd_sel(ForwardAE, rd1_q, ALUOutM, ResultW);
    fwd_b = fwd_sel(ForwardBE, rd2_q, ALUOutM, ResultW);
  end

  assign ValidE      = valid_q;
  assign RegWriteE   = regwrite_q;
  assign MemtoRegE   = memtoreg_q;
  assign MemWriteE   = memwrite_q;
  assign ALUControlE = aluctrl_q;
  assign SrcAE       = fwd_a;
  assign WriteDataE  = fwd_b;
  assign SrcBE       = alusrc_q ? signimm_q : fwd_b;
  assign WriteRegE   = regdst_q ? rd_q : rt_q;
  assign RsE         = rs_q;
  assign RtE         = rt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding, immediate/dest select,
// stall, flush-over-stall, invalid slot gating and reset during stall.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset, StallE, FlushE, ValidD;
  logic          RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]    ALUControlD;
  logic [DW-1:0] RD1D, RD2D, SignImmD, ALUOutM, ResultW;
  logic [RW-1:0] RsD, RtD, RdD;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ValidE, RegWriteE, MemtoRegE, MemWriteE;
  logic [2:0]    ALUControlE;
  logic [DW-1:0] SrcAE, SrcBE, WriteDataE;
  logic [RW-1:0] WriteRegE, RsE, RtE;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUOutM(ALUOutM), .ResultW(ResultW),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ValidE"},      64'(ValidE),      64'h0);
    check({tag, ".RegWriteE"},   64'(RegWriteE),   64'h0);
    check({tag, ".MemtoRegE"},   64'(MemtoRegE),   64'h0);
    check({tag, ".MemWriteE"},   64'(MemWriteE),   64'h0);
    check({tag, ".ALUControlE"}, 64'(ALUControlE), 64'h0);
    check({tag, ".SrcAE"},       64'(SrcAE),       64'h0);
    check({tag, ".SrcBE"},       64'(SrcBE),       64'h0);
    check({tag, ".WriteDataE"},  64'(WriteDataE),  64'h0);
    check({tag, ".WriteRegE"},   64'(WriteRegE),   64'h0);
    check({tag, ".RsE"},         64'(RsE),         64'h0);
    check({tag, ".RtE"},         64'(RtE),         64'h0);
  endtask

  // Forwarding table: {ForwardAE/BE, expected SrcAE, expected SrcBE/WriteDataE}
  logic [1:0]    fwd_sel_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [DW-1:0] fwd_exp_a   [4] = '{32'h5, 32'h10, 32'h20, 32'h5};
  logic [DW-1:0] fwd_exp_b   [4] = '{32'h3, 32'h10, 32'h20, 32'h3};

  initial begin
    // Non-zero D inputs during reset prove reset blocks the load path.
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b1;
    RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b0; RegDstD = 1'b1;
    ALUControlD = 3'b111; RD1D = 32'h1234; RD2D = 32'h5678; SignImmD = 32'h9;
    RsD = 5'd1; RtD = 5'd2; RdD = 5'd3; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUOutM = 32'h0; ResultW = 32'h0;
    tick(); tick();
    check_all_zero("reset");

    // 1. Load after reset
    reset = 1'b0; MemtoRegD = 1'b0; MemWriteD = 1'b0; RegDstD = 1'b0;
    RD1D = 32'h5; RD2D = 32'h3; ALUControlD = 3'b010;
    tick();
    check("load.SrcAE",       64'(SrcAE),       64'h5);
    check("load.SrcBE",       64'(SrcBE),       64'h3);
    check("load.ALUControlE", 64'(ALUControlE), 64'h2);
    check("load.RegWriteE",   64'(RegWriteE),   64'h1);
    check("load.ValidE",      64'(ValidE),      64'h1);

    // 2. Forwarding, combinational, no clock edge between steps
    ALUOutM = 32'h10; ResultW = 32'h20;
    for (int i = 0; i < 4; i++) begin
      ForwardAE = fwd_sel_tab[i]; ForwardBE = fwd_sel_tab[i];
      #1;
      check($sformatf("fwd%0d.SrcAE", i),      64'(SrcAE),      64'(fwd_exp_a[i]));
      check($sformatf("fwd%0d.SrcBE", i),      64'(SrcBE),      64'(fwd_exp_b[i]));
      check($sformatf("fwd%0d.WriteDataE", i), 64'(WriteDataE), 64'(fwd_exp_b[i]));
    end
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // 3. Immediate select and destination
    ALUSrcD = 1'b1; SignImmD = 32'hFFFF_FFFC; RD2D = 32'h7; RegDstD = 1'b1;
    RdD = 5'd9; RtD = 5'd4; RsD = 5'd6;
    tick();
    check("imm.SrcBE",      64'(SrcBE),      64'hFFFF_FFFC);
    check("imm.WriteDataE", 64'(WriteDataE), 64'h7);
    check("imm.WriteRegE",  64'(WriteRegE),  64'd9);
    check("imm.RsE",        64'(RsE),        64'd6);
    check("imm.RtE",        64'(RtE),        64'd4);
    RegDstD = 1'b0;
    tick();
    check("rt.WriteRegE",   64'(WriteRegE),  64'd4);

    // 4. Stall
    ALUSrcD = 1'b0; RD1D = 32'hA;
    tick();
    check("stall.load.SrcAE", 64'(SrcAE), 64'hA);
    StallE = 1'b1; RD1D = 32'hB;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.SrcAE", i), 64'(SrcAE), 64'hA);
    end
    StallE = 1'b0;
    tick();
    check("unstall.SrcAE", 64'(SrcAE), 64'hB);

    // 5. Flush beats stall
    RegWriteD = 1'b1; MemWriteD = 1'b1; MemtoRegD = 1'b1; ALUControlD = 3'b101;
    RegDstD = 1'b1; RdD = 5'd9; ValidD = 1'b1;
    tick();
    check("preflush.RegWriteE", 64'(RegWriteE), 64'h1);
    check("preflush.MemWriteE", 64'(MemWriteE), 64'h1);
    check("preflush.WriteRegE", 64'(WriteRegE), 64'd9);
    FlushE = 1'b1; StallE = 1'b1;
    tick();
    check_all_zero("flush");
    FlushE = 1'b0; StallE = 1'b0;

    // 6. Invalid slot gating: controls load but writes are suppressed
    ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; MemtoRegD = 1'b1;
    ALUControlD = 3'b011; RD1D = 32'h77;
    tick();
    check("inval.RegWriteE",   64'(RegWriteE),   64'h0);
    check("inval.MemWriteE",   64'(MemWriteE),   64'h0);
    check("inval.ValidE",      64'(ValidE),      64'h0);
    check("inval.MemtoRegE",   64'(MemtoRegE),   64'h1);
    check("inval.ALUControlE", 64'(ALUControlE), 64'h3);
    check("inval.SrcAE",       64'(SrcAE),       64'h77);

    // Reset during stall clears everything
    StallE = 1'b1; reset = 1'b1;
    tick();
    check_all_zero("stallrst");

    // First load after reset captures normally
    StallE = 1'b0; reset = 1'b0; ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b0;
    MemtoRegD = 1'b0; ALUControlD = 3'b110; RD1D = 32'h42; RegDstD = 1'b0; RtD = 5'd17;
    tick();
    check("postrst.ValidE",      64'(ValidE),      64'h1);
    check("postrst.RegWriteE",   64'(RegWriteE),   64'h1);
    check("postrst.ALUControlE", 64'(ALUControlE), 64'h6);
    check("postrst.SrcAE",       64'(SrcAE),       64'h42);
    check("postrst.WriteRegE",   64'(WriteRegE),   64'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
